// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and constants for the clock mode controller
//
// Purpose : FSM state encoding, field limits, tick terminal counts and the
//           edit_field display codes used by timer_mode_ctrl.
// Ports   : none (package)
package timer_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_EDIT_H = 2'd1,
    ST_EDIT_M = 2'd2,
    ST_EDIT_S = 2'd3
  } state_t;

  localparam logic [5:0] HOUR_MAX = 6'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;

  localparam int EDIT_TIMEOUT = 30;
  localparam int BEEP_TICKS   = 60;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  function automatic logic [1:0] field_code(input state_t s);
    case (s)
      ST_EDIT_H: field_code = FIELD_HOUR;
      ST_EDIT_M: field_code = FIELD_MIN;
      ST_EDIT_S: field_code = FIELD_SEC;
      default:   field_code = FIELD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/timer_tick_cnt.sv
// rtl/timer_tick_cnt.sv - 6-bit tick_1hz counter with clear and terminal flag
//
// Purpose : counts i_tick pulses; o_done marks the tick that reaches TERM.
// Ports   : i_clk, i_rst (sync, active high), i_clr (sync clear, wins over
//           i_tick), i_tick (count enable pulse), o_done (combinational,
//           high on the TERM-th counted tick)
module timer_tick_cnt #(
  parameter int TERM = 30
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_tick,
  output logic o_done
);

  localparam logic [5:0] TERM_M1 = 6'(TERM - 1);

  logic [5:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= 6'd0;
    end else if (i_tick) begin
      r_count <= (r_count == TERM_M1) ? 6'd0 : r_count + 6'd1;
    end
  end

  // A clear in the same cycle suppresses the flag so a button beats the tick.
  assign o_done = i_tick && !i_clr && (r_count == TERM_M1);

endmodule

// File: rtl/timer_mode_ctrl.sv
// rtl/timer_mode_ctrl.sv - time/alarm edit FSM and alarm beep control
//
// Purpose : walks hour/min/sec editing for time or alarm, issues load strobes,
//           times out idle edits and runs the 60 s alarm beep.
// Ports   : i_clk, i_rst (sync, active high), i_tick_1hz,
//           i_btn_set/i_btn_alm/i_btn_inc/i_btn_ok (1-clk pulses),
//           i_alarm_en (level), i_alarm_hit (pulse),
//           i_cur_hour/i_cur_min/i_cur_sec (fields of selected target),
//           o_tgt_alarm, o_hold_time, o_ld_hour/o_ld_min/o_ld_sec,
//           o_edit_val, o_edit_field, o_blink, o_beep_req (all registered)
module timer_mode_ctrl (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick_1hz,
  input  logic       i_btn_set,
  input  logic       i_btn_alm,
  input  logic       i_btn_inc,
  input  logic       i_btn_ok,
  input  logic       i_alarm_en,
  input  logic       i_alarm_hit,
  input  logic [4:0] i_cur_hour,
  input  logic [5:0] i_cur_min,
  input  logic [5:0] i_cur_sec,
  output logic       o_tgt_alarm,
  output logic       o_hold_time,
  output logic       o_ld_hour,
  output logic       o_ld_min,
  output logic       o_ld_sec,
  output logic [5:0] o_edit_val,
  output logic [1:0] o_edit_field,
  output logic       o_blink,
  output logic       o_beep_req
);

  import timer_pkg::*;

  state_t     r_state, w_next_state;
  logic       r_tgt, w_next_tgt;
  logic       r_first, r_hold, r_blink, w_next_blink, r_beep;
  logic [2:0] r_ld, w_ld;                 // {hour, min, sec}
  logic [5:0] r_edit_val, w_next_val;
  logic [5:0] w_cur, w_max, w_base, w_inc_val;
  logic [1:0] r_field;
  logic       w_any_btn, w_set, w_alm, w_inc, w_ok;
  logic       w_to_clr, w_to_done, w_beep_clr, w_beep_done, w_hit_ok;

  // While the beeper sounds, any button only silences it.
  assign w_any_btn = i_btn_set | i_btn_alm | i_btn_inc | i_btn_ok;
  assign w_set     = i_btn_set && !r_beep;
  assign w_alm     = i_btn_alm && !r_beep;
  assign w_inc     = i_btn_inc && !r_beep;
  assign w_ok      = i_btn_ok  && !r_beep;

  assign w_max = (r_state == ST_EDIT_H) ? HOUR_MAX : MIN_MAX;
  assign w_cur = (r_state == ST_EDIT_H) ? {1'b0, i_cur_hour} :
                 (r_state == ST_EDIT_M) ? i_cur_min : i_cur_sec;

  // First cycle of a field takes the live value (clamped), later cycles the
  // edit register; buttons in that first cycle then act on the loaded value.
  assign w_base    = r_first ? ((w_cur > w_max) ? w_max : w_cur) : r_edit_val;
  assign w_inc_val = (w_base >= w_max) ? 6'd0 : w_base + 6'd1;

  assign w_to_clr   = (r_state == ST_RUN) || w_any_btn;
  assign w_hit_ok   = i_alarm_hit && i_alarm_en && (r_state == ST_RUN);
  assign w_beep_clr = !r_beep || w_hit_ok;

  timer_tick_cnt #(.TERM(EDIT_TIMEOUT)) u_timeout (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_to_clr),
    .i_tick (i_tick_1hz),
    .o_done (w_to_done)
  );

  timer_tick_cnt #(.TERM(BEEP_TICKS)) u_beep (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_beep_clr),
    .i_tick (i_tick_1hz),
    .o_done (w_beep_done)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_tgt   = r_tgt;
    w_next_val   = r_edit_val;
    w_ld         = 3'b000;
    w_next_blink = r_blink;

    if (r_state == ST_RUN) begin
      if (w_set) begin
        w_next_state = ST_EDIT_H;
        w_next_tgt   = 1'b0;
      end else if (w_alm) begin
        w_next_state = ST_EDIT_H;
        w_next_tgt   = 1'b1;
      end
    end else begin
      w_next_val = w_base;
      if (w_set) begin
        w_next_state = ST_RUN;
      end else if (w_ok) begin
        if (r_state == ST_EDIT_H) begin
          w_ld         = 3'b100;
          w_next_state = ST_EDIT_M;
        end else if (r_state == ST_EDIT_M) begin
          w_ld         = 3'b010;
          w_next_state = ST_EDIT_S;
        end else begin
          w_ld         = 3'b001;
          w_next_state = ST_RUN;
        end
      end else if (w_inc) begin
        w_next_val = w_inc_val;
      end else if (w_to_done) begin
        w_next_state = ST_RUN;
      end
    end

    if (w_next_state == ST_RUN) begin
      w_next_blink = 1'b0;
    end else if (w_next_state != r_state) begin
      w_next_blink = 1'b1;
    end else if (i_tick_1hz) begin
      w_next_blink = ~r_blink;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_RUN;
      r_tgt      <= 1'b0;
      r_edit_val <= 6'd0;
      r_ld       <= 3'b000;
      r_first    <= 1'b0;
      r_hold     <= 1'b0;
      r_field    <= FIELD_NONE;
      r_blink    <= 1'b0;
      r_beep     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_tgt      <= w_next_tgt;
      r_edit_val <= w_next_val;
      r_ld       <= w_ld;
      r_first    <= (w_next_state != ST_RUN) && (w_next_state != r_state);
      r_hold     <= (w_next_state != ST_RUN) && !w_next_tgt;
      r_field    <= field_code(w_next_state);
      r_blink    <= w_next_blink;
      if (!i_alarm_en || w_any_btn) begin
        r_beep <= 1'b0;
      end else if (w_hit_ok) begin
        r_beep <= 1'b1;
      end else if (w_beep_done) begin
        r_beep <= 1'b0;
      end
    end
  end

  assign o_tgt_alarm  = r_tgt;
  assign o_hold_time  = r_hold;
  assign o_ld_hour    = r_ld[2];
  assign o_ld_min     = r_ld[1];
  assign o_ld_sec     = r_ld[0];
  assign o_edit_val   = r_edit_val;
  assign o_edit_field = r_field;
  assign o_blink      = r_blink;
  assign o_beep_req   = r_beep;

endmodule

// File: tb/tb_timer_mode_ctrl.sv
// tb/tb_timer_mode_ctrl.sv - scoreboard bench for timer_mode_ctrl
module tb_timer_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst, tick, bset, balm, binc, bok, alarm_en, alarm_hit;
  logic [4:0] cur_hour;
  logic [5:0] cur_min, cur_sec;
  logic       o_tgt, o_hold, o_ldh, o_ldm, o_lds, o_blink, o_beep;
  logic [5:0] o_val;
  logic [1:0] o_field;

  always #5 clk = ~clk;

  timer_mode_ctrl dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_tick_1hz   (tick),
    .i_btn_set    (bset),
    .i_btn_alm    (balm),
    .i_btn_inc    (binc),
    .i_btn_ok     (bok),
    .i_alarm_en   (alarm_en),
    .i_alarm_hit  (alarm_hit),
    .i_cur_hour   (cur_hour),
    .i_cur_min    (cur_min),
    .i_cur_sec    (cur_sec),
    .o_tgt_alarm  (o_tgt),
    .o_hold_time  (o_hold),
    .o_ld_hour    (o_ldh),
    .o_ld_min     (o_ldm),
    .o_ld_sec     (o_lds),
    .o_edit_val   (o_val),
    .o_edit_field (o_field),
    .o_blink      (o_blink),
    .o_beep_req   (o_beep)
  );

  typedef struct {
    int         due;
    logic       tgt, hold;
    logic [2:0] ld;
    logic [5:0] val;
    logic [1:0] field;
    logic       blink, beep;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: mode 0 = running, 1/2/3 = editing hour/min/sec.
  int       m_mode = 0, m_val = 0, m_idle = 0, m_bticks = 0;
  bit       m_tgt = 0, m_fresh = 0, m_blink = 0, m_beep = 0;
  bit [2:0] m_ld = 0;

  task automatic model_step();
    bit any, consumed, entered;
    int old, fmax, fval;
    if (rst) begin
      m_mode = 0; m_val = 0; m_idle = 0; m_bticks = 0;
      m_tgt = 0; m_fresh = 0; m_blink = 0; m_beep = 0; m_ld = 0;
      return;
    end
    any      = bset | balm | binc | bok;
    consumed = m_beep && any;
    old      = m_mode;
    entered  = 0;
    m_ld     = 0;

    if (!alarm_en || any) m_beep = 0;
    else if (old == 0 && alarm_hit) begin
      m_beep = 1; m_bticks = 0;
    end else if (m_beep && tick) begin
      m_bticks++;
      if (m_bticks >= 60) m_beep = 0;
    end

    if (any) m_idle = 0;
    if (!consumed) begin
      if (old == 0) begin
        if (bset) begin m_mode = 1; m_tgt = 0; entered = 1; end
        else if (balm) begin m_mode = 1; m_tgt = 1; entered = 1; end
      end else begin
        fmax = (old == 1) ? 23 : 59;
        fval = (old == 1) ? int'(cur_hour) : (old == 2) ? int'(cur_min) : int'(cur_sec);
        if (m_fresh) begin
          m_val   = (fval > fmax) ? fmax : fval;
          m_fresh = 0;
        end
        if (bset) m_mode = 0;
        else if (bok) begin
          m_ld    = 3'b100 >> (old - 1);
          m_mode  = (old == 3) ? 0 : old + 1;
          entered = (m_mode != 0);
        end else if (binc) m_val = (m_val == fmax) ? 0 : m_val + 1;
        else if (tick && !any) begin
          m_idle++;
          if (m_idle == 30) m_mode = 0;
        end
      end
    end
    if (entered) begin m_fresh = 1; m_idle = 0; end
    if (m_mode == 0) m_blink = 0;
    else if (entered) m_blink = 1;
    else if (tick) m_blink = !m_blink;
  endtask

  task automatic cyc1(input bit s, input bit a, input bit inc, input bit ok,
                      input bit tk, input bit hit);
    exp_t e;
    bset = s; balm = a; binc = inc; bok = ok; tick = tk; alarm_hit = hit;
    model_step();
    e.due   = cyc + 1;
    e.tgt   = m_tgt;
    e.hold  = (m_mode != 0) && !m_tgt;
    e.ld    = m_ld;
    e.val   = m_val[5:0];
    e.field = m_mode[1:0];
    e.blink = m_blink;
    e.beep  = m_beep;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc1(0, 0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      cyc1(0, 0, 0, 0, 1, 0);
      cyc1(0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      check("tgt_alarm",  o_tgt,                 e.tgt);
      check("hold_time",  o_hold,                e.hold);
      check("ld_strobes", {o_ldh, o_ldm, o_lds}, e.ld);
      check("edit_val",   o_val,                 e.val);
      check("edit_field", o_field,               e.field);
      check("blink",      o_blink,               e.blink);
      check("beep_req",   o_beep,                e.beep);
    end
  end

  initial begin
    rst = 1; tick = 0; bset = 0; balm = 0; binc = 0; bok = 0;
    alarm_en = 0; alarm_hit = 0;
    cur_hour = 5'd22; cur_min = 6'd34; cur_sec = 6'd45;
    @(posedge clk);
    #1;
    idle(3);
    rst = 0;
    idle(2);

    // time set: 22 -> 23 -> 0 -> 1, load hour, then abort in EDIT_M
    cyc1(1, 0, 0, 0, 0, 0);
    idle(1);
    repeat (3) cyc1(0, 0, 1, 0, 0, 0);
    cyc1(0, 0, 0, 1, 0, 0);
    idle(2);
    cyc1(1, 0, 0, 0, 0, 0);
    idle(2);

    // alarm set through all three fields
    cyc1(0, 1, 0, 0, 0, 0);
    repeat (3) begin
      idle(1);
      cyc1(0, 0, 0, 1, 0, 0);
    end
    idle(2);

    // idle timeout in EDIT_S
    cyc1(1, 0, 0, 0, 0, 0);
    cyc1(0, 0, 0, 1, 0, 0);
    cyc1(0, 0, 0, 1, 0, 0);
    idle(1);
    ticks(30);
    idle(2);

    // button on the 29th tick restarts the timeout
    cyc1(1, 0, 0, 0, 0, 0);
    cyc1(0, 0, 0, 1, 0, 0);
    cyc1(0, 0, 0, 1, 0, 0);
    idle(1);
    ticks(28);
    cyc1(0, 0, 1, 0, 1, 0);
    idle(1);
    ticks(2);
    cyc1(1, 0, 0, 0, 0, 0);
    idle(1);

    // beep: full 60 ticks, then silenced by a button at tick 10
    alarm_en = 1;
    cyc1(0, 0, 0, 0, 0, 1);
    ticks(62);
    idle(2);
    cyc1(0, 0, 0, 0, 0, 1);
    ticks(10);
    cyc1(0, 0, 0, 1, 0, 0);
    idle(2);

    // restart while sounding, then disarm
    cyc1(0, 0, 0, 0, 0, 1);
    ticks(20);
    cyc1(0, 0, 0, 0, 0, 1);
    ticks(30);
    alarm_en = 0;
    idle(2);
    alarm_en = 1;

    // simultaneous buttons
    cyc1(1, 1, 0, 0, 0, 0);
    idle(1);
    cyc1(1, 0, 1, 1, 0, 0);
    idle(2);

    // reset in EDIT_M together with btn_ok
    cyc1(1, 0, 0, 0, 0, 0);
    idle(1);
    cyc1(0, 0, 0, 1, 0, 0);
    idle(1);
    rst = 1;
    cyc1(0, 0, 0, 1, 0, 0);
    rst = 0;
    idle(2);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cur_hour = 5'($urandom_range(0, 31));
      cur_min  = 6'($urandom_range(0, 63));
      cur_sec  = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 199) == 0) alarm_en = ~alarm_en;
      rst = ($urandom_range(0, 599) == 0);
      cyc1($urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 5) == 0,  $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) == 0,  $urandom_range(0, 39) == 0);
    end
    rst = 0;
    idle(2);

    repeat (2) @(negedge clk);
    #1;
    check("scoreboard_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
